// File: rtl/switch_debounce_if.sv
// Switch debounce port bundle: raw switch pins in, debounced pattern and
// change pulse out. WIDTH must match the WIDTH of the attached debouncer.
interface switch_debounce_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] switches_raw;
  logic [WIDTH-1:0] switches_out;
  logic             update;

  // Board / bench side: drives pins, observes debounced result
  modport master (
    output switches_raw,
    input  switches_out,
    input  update
  );

  // Debouncer side
  modport slave (
    input  switches_raw,
    output switches_out,
    output update
  );
endinterface

// File: rtl/switch_debounce.sv
// Synchronises and debounces the active-low mode switches. A new pattern is
// forwarded only after it has been steady for DEBOUNCE_CYCLES clocks, and a
// one-cycle update pulse marks each accepted change of switches_out.
module switch_debounce #(
  parameter int               WIDTH           = 5,
  parameter int               DEBOUNCE_CYCLES = 270000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input logic             clock,
  input logic             reset,
  switch_debounce_if.slave sw
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt;
  logic             r_update;
  state_t           r_state;

  logic             w_changed;

  // The candidate is compared against the synchronised value only; any bit
  // moving restarts the window regardless of which bit it is.
  assign w_changed = (r_sync2 != r_cand);

  // Two-flop synchroniser; the only consumer of the asynchronous pins
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
    end else begin
      r_sync1 <= sw.switches_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM: track a candidate pattern, count its stable clocks and
  // publish it (with a single-cycle pulse) once the window expires
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cand   <= RESET_VALUE;
      r_out    <= RESET_VALUE;
      r_cnt    <= '0;
      r_update <= 1'b0;
      r_state  <= ST_STABLE;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (w_changed) begin
            r_cand  <= r_sync2;
            r_cnt   <= '0;
            r_state <= ST_COUNTING;
          end
        end
        ST_COUNTING: begin
          if (w_changed) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
          end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            // Window expired; a bounce back to the current output is
            // absorbed silently
            r_state <= ST_STABLE;
            if (r_cand != r_out) begin
              r_out    <= r_cand;
              r_update <= 1'b1;
            end
          end
        end
        default: r_state <= ST_STABLE;
      endcase
    end
  end

  assign sw.switches_out = r_out;
  assign sw.update       = r_update;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed timing scenarios plus randomized
// bouncing, all compared each cycle against a run-length reference model.
module tb_switch_debounce;
  localparam int               W  = 5;
  localparam int               D  = 4;
  localparam logic [W-1:0]     RV = '1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  switch_debounce_if #(.WIDTH(W)) sw ();

  switch_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .RESET_VALUE(RV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw   (sw)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the debouncer sees each pin sample two edges late; a
  // pattern is published once it has been seen on D+1 consecutive edges and
  // differs from what is currently published.
  logic [W-1:0] dly [2];
  logic [W-1:0] cur, m_out, d;
  logic         m_upd;
  int           run;
  bit           model_on = 0;

  always @(posedge clock) begin
    if (reset) begin
      dly[0] = RV; dly[1] = RV;
      cur = RV; run = 1; m_out = RV; m_upd = 1'b0;
      model_on = 1;
    end else begin
      d      = dly[1];
      dly[1] = dly[0];
      dly[0] = sw.switches_raw;
      if (d == cur) begin
        if (run < D + 1) run++;
      end else begin
        cur = d;
        run = 1;
      end
      m_upd = (run >= D + 1) && (cur != m_out);
      if (m_upd) m_out = cur;
    end
  end

  int upd_cnt = 0;
  bit seen_11101 = 0;

  always @(negedge clock) begin
    if (model_on) begin
      chk("model_out", 32'(sw.switches_out), 32'(m_out));
      chk("model_upd", 32'(sw.update), 32'(m_upd));
    end
    if (sw.update) upd_cnt++;
    if (sw.switches_out == 5'b11101) seen_11101 = 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  int snap;

  initial begin
    sw.switches_raw = RV;
    reset = 1'b1;

    // 1: reset held 3 clocks
    tick(3);
    chk("s1_rst_out", 32'(sw.switches_out), 32'(RV));
    chk("s1_rst_upd", 32'(sw.update), 32'd0);
    reset = 1'b0;
    snap = upd_cnt;
    tick(10);
    chk("s1_idle_out", 32'(sw.switches_out), 32'(RV));
    chk("s1_no_pulse", 32'(upd_cnt - snap), 32'd0);

    // 2: single change, exact latency E0+6
    sw.switches_raw = 5'b11110;
    tick(6);
    chk("s2_upd_e5", 32'(sw.update), 32'd0);
    chk("s2_out_e5", 32'(sw.switches_out), 32'(RV));
    tick(1);
    chk("s2_upd_e6", 32'(sw.update), 32'd1);
    chk("s2_out_e6", 32'(sw.switches_out), 32'h1E);
    tick(1);
    chk("s2_upd_e7", 32'(sw.update), 32'd0);
    tick(10);

    // back to none pressed
    sw.switches_raw = RV;
    tick(12);
    chk("s3_pre_out", 32'(sw.switches_out), 32'(RV));

    // 3: short glitch bounces back
    snap = upd_cnt;
    sw.switches_raw = 5'b11110;
    tick(2);
    sw.switches_raw = RV;
    tick(15);
    chk("s3_out", 32'(sw.switches_out), 32'(RV));
    chk("s3_pulses", 32'(upd_cnt - snap), 32'd0);

    // 4: staggered multi-bit change
    snap = upd_cnt;
    seen_11101 = 0;
    sw.switches_raw = 5'b11101;
    tick(3);
    sw.switches_raw = 5'b11001;
    tick(6);
    chk("s4_upd_e5", 32'(sw.update), 32'd0);
    tick(1);
    chk("s4_upd_e6", 32'(sw.update), 32'd1);
    chk("s4_out", 32'(sw.switches_out), 32'h19);
    tick(10);
    chk("s4_pulses", 32'(upd_cnt - snap), 32'd1);
    chk("s4_no_11101", 32'(seen_11101), 32'd0);

    // 5: heavy bouncing then settle
    for (int i = 0; i < 50; i++) begin
      sw.switches_raw = (i % 2 == 1) ? RV : 5'b11011;
      tick(1);
    end
    snap = upd_cnt;
    sw.switches_raw = 5'b11011;
    tick(6);
    chk("s5_upd_e5", 32'(sw.update), 32'd0);
    tick(1);
    chk("s5_upd_e6", 32'(sw.update), 32'd1);
    chk("s5_out", 32'(sw.switches_out), 32'h1B);
    tick(10);
    chk("s5_pulses", 32'(upd_cnt - snap), 32'd1);

    // 6: reset mid-count
    sw.switches_raw = 5'b11110;
    tick(12);
    chk("s6_pre_out", 32'(sw.switches_out), 32'h1E);
    sw.switches_raw = 5'b01111;
    tick(5);
    reset = 1'b1;
    tick(2);
    chk("s6_rst_out", 32'(sw.switches_out), 32'(RV));
    chk("s6_rst_upd", 32'(sw.update), 32'd0);
    reset = 1'b0;
    tick(6);
    chk("s6_upd_f5", 32'(sw.update), 32'd0);
    chk("s6_out_f5", 32'(sw.switches_out), 32'(RV));
    tick(1);
    chk("s6_upd_f6", 32'(sw.update), 32'd1);
    chk("s6_out_f6", 32'(sw.switches_out), 32'h0F);
    tick(5);

    // Randomized bouncing with occasional resets; model compares every cycle
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       sw.switches_raw = RV;
        1:       sw.switches_raw = 5'b11110;
        2:       sw.switches_raw = 5'b10111;
        default: sw.switches_raw = W'($urandom);
      endcase
      reset = ($urandom_range(0, 39) == 0);
      tick($urandom_range(1, 9));
      reset = 1'b0;
    end
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
